// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC and sequences instruction fetch.
// The PC is word-addressed and advances only on an accepted fetch
// (RUN, memory ready, no stall). Redirects from EX (taken branch) and ID
// (jump/jr) are arbitrated with EX winning. A redirect that arrives while
// fetch cannot advance is parked and applied on the next accepted fetch.
//
// Ports:
//   clk          system clock; all state changes on posedge
//   reset        synchronous active-low reset
//   stall        hazard-unit stall; blocks fetch advance
//   imem_ready   instruction memory data valid for imem_addr
//   id_redirect  jump/jr resolved in ID, target on id_target
//   ex_redirect  taken branch resolved in EX, target on ex_target
//   halt         halt decoded; stop fetching after this fetch
//   imem_addr    byte address {pc, 2'b00}
//   imem_req     fetch request active
//   pc           current fetch PC (words)
//   if_valid     fetched word is correct-path; IF/ID may latch
//   flush_ifid   squash IF/ID this cycle
//   flush_idex   squash ID/EX this cycle
//   fetch_count  number of if_valid cycles, wraps mod 2^32
module fetch_sequencer #(
  parameter int unsigned    PC_W     = 30,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            imem_ready,
  input  logic            id_redirect,
  input  logic [PC_W-1:0] id_target,
  input  logic            ex_redirect,
  input  logic [PC_W-1:0] ex_target,
  input  logic            halt,
  output logic [31:0]     imem_addr,
  output logic            imem_req,
  output logic [PC_W-1:0] pc,
  output logic            if_valid,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e          r_state, w_state_d;
  logic [PC_W-1:0] r_pc, w_pc_d;
  logic            r_pend_valid, w_pend_valid_d;
  logic            r_pend_from_ex, w_pend_from_ex_d;
  logic [PC_W-1:0] r_pend_target, w_pend_target_d;
  logic [31:0]     r_fetch_count;

  logic            w_run;
  logic            w_adv;
  logic            w_redir;
  logic [PC_W-1:0] w_redir_target;
  logic            w_fetch;

  assign w_run          = (r_state == StRun);
  assign w_adv          = w_run & imem_ready & ~stall;
  assign w_redir        = ex_redirect | id_redirect;
  // The branch in EX is older than the jump in ID, so it wins.
  assign w_redir_target = ex_redirect ? ex_target : id_target;
  assign w_fetch        = w_adv & ~w_redir & ~r_pend_valid;

  always_comb begin
    w_state_d        = r_state;
    w_pc_d           = r_pc;
    w_pend_valid_d   = r_pend_valid;
    w_pend_from_ex_d = r_pend_from_ex;
    w_pend_target_d  = r_pend_target;

    unique case (r_state)
      StIdle: w_state_d = StRun;
      StRun: begin
        if (w_adv) begin
          if (w_redir) begin
            // A live redirect supersedes anything parked.
            w_pc_d         = w_redir_target;
            w_pend_valid_d = 1'b0;
          end else if (r_pend_valid) begin
            w_pc_d         = r_pend_target;
            w_pend_valid_d = 1'b0;
          end else begin
            w_pc_d = r_pc + PC_W'(1);
            if (halt) w_state_d = StHalted;
          end
        end else if (ex_redirect) begin
          w_pend_valid_d   = 1'b1;
          w_pend_from_ex_d = 1'b1;
          w_pend_target_d  = ex_target;
        end else if (id_redirect && !(r_pend_valid && r_pend_from_ex)) begin
          // An ID redirect behind a parked EX redirect is wrong-path.
          w_pend_valid_d   = 1'b1;
          w_pend_from_ex_d = 1'b0;
          w_pend_target_d  = id_target;
        end
      end
      StHalted: w_state_d = StHalted;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= StIdle;
      r_pc           <= RESET_PC;
      r_pend_valid   <= 1'b0;
      r_pend_from_ex <= 1'b0;
      r_pend_target  <= '0;
      r_fetch_count  <= '0;
    end else begin
      r_state        <= w_state_d;
      r_pc           <= w_pc_d;
      r_pend_valid   <= w_pend_valid_d;
      r_pend_from_ex <= w_pend_from_ex_d;
      r_pend_target  <= w_pend_target_d;
      if (w_fetch) r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign imem_addr   = 32'({r_pc, 2'b00});
  assign imem_req    = w_run;
  assign pc          = r_pc;
  assign if_valid    = w_fetch;
  assign flush_ifid  = w_run & w_redir;
  assign flush_idex  = w_run & ex_redirect;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        imem_ready;
  logic        id_redirect;
  logic [29:0] id_target;
  logic        ex_redirect;
  logic [29:0] ex_target;
  logic        halt;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [29:0] pc;
  logic        if_valid;
  logic        flush_ifid;
  logic        flush_idex;
  logic [31:0] fetch_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(30), .RESET_PC(30'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .imem_ready  (imem_ready),
    .id_redirect (id_redirect),
    .id_target   (id_target),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .halt        (halt),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .pc          (pc),
    .if_valid    (if_valid),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .fetch_count (fetch_count)
  );

  task automatic check(input string tag, input logic ok, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1ns after the edge, then let comb settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; imem_ready = 1'b0; halt = 1'b0;
    id_redirect = 1'b0; id_target = '0; ex_redirect = 1'b0; ex_target = '0;

    // Reset
    tick(); tick();
    settle();
    check("rst_pc", pc === 30'h0, 32'(pc), 32'h0);
    check("rst_req", imem_req === 1'b0, 32'(imem_req), 32'h0);
    check("rst_cnt", fetch_count === 32'd0, fetch_count, 32'd0);
    check("rst_addr", imem_addr === 32'h0, imem_addr, 32'h0);
    check("rst_valid", if_valid === 1'b0, 32'(if_valid), 32'h0);

    // Release: one bubble in IDLE
    reset = 1'b1; imem_ready = 1'b1;
    settle();
    check("bubble_req", imem_req === 1'b0, 32'(imem_req), 32'h0);
    check("bubble_flush", flush_ifid === 1'b0, 32'(flush_ifid), 32'h0);
    tick(); settle();
    check("run_req", imem_req === 1'b1, 32'(imem_req), 32'h1);

    // Stream 0..3
    for (int i = 0; i < 4; i++) begin
      check("stream_pc", pc === 30'(i), 32'(pc), 32'(i));
      check("stream_valid", if_valid === 1'b1, 32'(if_valid), 32'h1);
      tick(); settle();
    end
    check("stream_cnt", fetch_count === 32'd4, fetch_count, 32'd4);
    tick(); settle();
    check("pc5", pc === 30'd5, 32'(pc), 32'd5);

    // Stall 2 cycles, then memory wait 3 cycles
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin stall = 1'b0; imem_ready = 1'b0; end
      settle();
      check("hold_pc", pc === 30'd5, 32'(pc), 32'd5);
      check("hold_valid", if_valid === 1'b0, 32'(if_valid), 32'h0);
      tick();
    end
    imem_ready = 1'b1;
    settle();
    check("resume_valid", if_valid === 1'b1, 32'(if_valid), 32'h1);
    tick(); settle();
    check("resume_pc", pc === 30'd6, 32'(pc), 32'd6);
    check("resume_cnt", fetch_count === 32'd6, fetch_count, 32'd6);
    tick(); tick(); settle();
    check("pc8", pc === 30'd8, 32'(pc), 32'd8);

    // Simultaneous redirects: EX wins
    ex_redirect = 1'b1; ex_target = 30'h40;
    id_redirect = 1'b1; id_target = 30'h80;
    settle();
    check("sim_fifid", flush_ifid === 1'b1, 32'(flush_ifid), 32'h1);
    check("sim_fidex", flush_idex === 1'b1, 32'(flush_idex), 32'h1);
    check("sim_valid", if_valid === 1'b0, 32'(if_valid), 32'h0);
    tick();
    id_redirect = 1'b0; ex_redirect = 1'b0;
    settle();
    check("sim_pc", pc === 30'h40, 32'(pc), 32'h40);
    check("sim_cnt", fetch_count === 32'd8, fetch_count, 32'd8);

    // Pending redirect: get to pc=10 first
    ex_redirect = 1'b1; ex_target = 30'd10;
    tick();
    ex_redirect = 1'b0; imem_ready = 1'b0;
    id_redirect = 1'b1; id_target = 30'h20;
    settle();
    check("pend_pc10", pc === 30'd10, 32'(pc), 32'd10);
    check("pend_fifid", flush_ifid === 1'b1, 32'(flush_ifid), 32'h1);
    check("pend_fidex", flush_idex === 1'b0, 32'(flush_idex), 32'h0);
    check("pend_valid0", if_valid === 1'b0, 32'(if_valid), 32'h0);
    tick();
    id_redirect = 1'b0; ex_redirect = 1'b1; ex_target = 30'h30;
    tick();
    ex_redirect = 1'b0; id_redirect = 1'b1; id_target = 30'h50;
    tick();
    id_redirect = 1'b0; imem_ready = 1'b1;
    settle();
    check("pend_hold_pc", pc === 30'd10, 32'(pc), 32'd10);
    check("pend_adv_valid", if_valid === 1'b0, 32'(if_valid), 32'h0);
    tick(); settle();
    check("pend_pc30", pc === 30'h30, 32'(pc), 32'h30);
    check("pend_valid1", if_valid === 1'b1, 32'(if_valid), 32'h1);
    tick(); settle();
    check("pend_pc31", pc === 30'h31, 32'(pc), 32'h31);
    check("pend_cnt", fetch_count === 32'd9, fetch_count, 32'd9);

    // Halt at pc=12
    ex_redirect = 1'b1; ex_target = 30'd12;
    tick();
    ex_redirect = 1'b0; halt = 1'b1;
    settle();
    check("halt_pc12", pc === 30'd12, 32'(pc), 32'd12);
    check("halt_valid", if_valid === 1'b1, 32'(if_valid), 32'h1);
    tick();
    halt = 1'b0;
    settle();
    check("halt_pc13", pc === 30'd13, 32'(pc), 32'd13);
    for (int i = 0; i < 10; i++) begin
      check("halted_pc", pc === 30'd13, 32'(pc), 32'd13);
      check("halted_req", imem_req === 1'b0, 32'(imem_req), 32'h0);
      check("halted_valid", if_valid === 1'b0, 32'(if_valid), 32'h0);
      tick(); settle();
    end
    check("halted_cnt", fetch_count === 32'd10, fetch_count, 32'd10);

    // Reset out of HALTED, then halt with a simultaneous EX redirect
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick(); settle();
    check("rerun_pc", pc === 30'd0, 32'(pc), 32'd0);
    check("rerun_cnt", fetch_count === 32'd0, fetch_count, 32'd0);
    ex_redirect = 1'b1; ex_target = 30'd12;
    tick();
    ex_target = 30'h44; halt = 1'b1;
    settle();
    check("hr_valid", if_valid === 1'b0, 32'(if_valid), 32'h0);
    tick();
    ex_redirect = 1'b0; halt = 1'b0;
    settle();
    check("hr_pc", pc === 30'h44, 32'(pc), 32'h44);
    check("hr_req", imem_req === 1'b1, 32'(imem_req), 32'h1);
    check("hr_valid_run", if_valid === 1'b1, 32'(if_valid), 32'h1);
    tick(); settle();
    check("hr_pc45", pc === 30'h45, 32'(pc), 32'h45);

    // Reset discards a pending redirect
    imem_ready = 1'b0; id_redirect = 1'b1; id_target = 30'h99;
    tick();
    id_redirect = 1'b0; reset = 1'b0;
    tick(); settle();
    check("mid_rst_pc", pc === 30'd0, 32'(pc), 32'd0);
    check("mid_rst_cnt", fetch_count === 32'd0, fetch_count, 32'd0);
    reset = 1'b1; imem_ready = 1'b1;
    tick(); settle();
    check("mid_rst_valid", if_valid === 1'b1, 32'(if_valid), 32'h1);
    tick(); settle();
    check("mid_rst_pc1", pc === 30'd1, 32'(pc), 32'd1);

    // PC wrap
    ex_redirect = 1'b1; ex_target = 30'h3FFFFFFF;
    tick();
    ex_redirect = 1'b0;
    settle();
    check("wrap_pcmax", pc === 30'h3FFFFFFF, 32'(pc), 32'h3FFFFFFF);
    check("wrap_addr", imem_addr === 32'hFFFFFFFC, imem_addr, 32'hFFFFFFFC);
    tick(); settle();
    check("wrap_pc0", pc === 30'd0, 32'(pc), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control block that owns the program counter and sequences instruction fetch for the pipelined CPU. It drives the word-addressed PC into instruction memory and advances it on accepted fetches. It arbitrates redirect requests from decode (jump/jr) and execute (taken branch), holds a redirect that arrives while fetch cannot advance, and generates the pipeline flush and valid signals. It sits between the hazard unit, ID/EX redirect logic and InstructionMem.

Parameters:
PC_W, 30, PC width in words; byte address = {pc, 2'b00}.
RESET_PC, 30'h0, word address loaded on reset.

Ports:
clk  in  1  system clock, all state changes on posedge.
reset  in  1  synchronous, active-low reset; sampled on posedge clk.
stall  in  1  hazard-unit stall; fetch must not advance while high.
imem_ready  in  1  instruction memory has valid data for imem_addr this cycle.
id_redirect  in  1  jump/jr resolved in ID this cycle.
id_target  in  PC_W  word target for id_redirect; already fully composed.
ex_redirect  in  1  taken branch resolved in EX this cycle.
ex_target  in  PC_W  word target for ex_redirect.
halt  in  1  halt instruction decoded; stop fetching.
imem_addr  out  32  {pc, 2'b00}.
imem_req  out  1  fetch request active.
pc  out  PC_W  current fetch PC.
if_valid  out  1  instruction on imem bus is correct-path; IF/ID may latch it.
flush_ifid  out  1  squash IF/ID this cycle.
flush_idex  out  1  squash ID/EX this cycle.
fetch_count  out  32  count of if_valid cycles; wraps mod 2^32.

Behaviour:
- FSM states: IDLE, RUN, HALTED.
- Reset low at posedge: state=IDLE, pc=RESET_PC, pend_valid=0, pend_from_ex=0, fetch_count=0. This overrides all other inputs, including in the middle of a pending redirect or a halt.
- Outputs while in IDLE: imem_req=0, if_valid=0, flush_ifid=0, flush_idex=0.
- IDLE -> RUN unconditionally at the next posedge after reset goes high. This gives exactly one bubble.
- RUN: imem_req=1.
- Define adv = (state==RUN) & imem_ready & ~stall.
- Define redir = ex_redirect | id_redirect. When both are high in the same cycle, ex wins: ex_target is used and the id request is dropped, because the branch is older.
- flush_ifid = redir (combinational, same cycle) while in RUN. It is 0 in IDLE and HALTED.
- flush_idex = ex_redirect while in RUN. It is 0 in IDLE and HALTED.
- Next-PC priority when adv=1:
  1. Live redirect: pc <= selected target, if_valid=0.
  2. Otherwise, if pend_valid: pc <= pend_target, pend_valid <= 0, if_valid=0.
  3. Otherwise: pc <= pc+1 (wraps mod 2^PC_W), if_valid=1.
- When adv=0 and redir=1: pc holds, and the redirect is stored as pend_target/pend_valid=1.
  - A pending id entry is overwritten by any new ex or id redirect.
  - A pending ex entry is overwritten only by a new ex redirect; a new id redirect is ignored because it is wrong-path.
- When adv=0 and redir=0: pc and the pending state hold, and if_valid=0.
- if_valid is 0 whenever adv=0.
- fetch_count increments in every cycle where if_valid=1.
- halt is acted on only when adv=1 and redir=0:
  - the fetch that cycle completes with if_valid=1;
  - pc advances;
  - state -> HALTED.
  A redirect in the same cycle takes precedence and the halt is ignored, because the halt instruction is wrong-path.
- HALTED: imem_req=0, if_valid=0, flushes 0, pc frozen. Only reset leaves this state.
- imem_addr always equals {pc, 2'b00}, including in IDLE and HALTED.

Test Plan:
- Reset and stream:
  - Stimulus: RESET_PC=0; reset low 2 cycles, then high; imem_ready=1, stall=0.
  - Response: imem_req=0 for 1 cycle after release, then pc = 0, 1, 2, 3…; if_valid=1 each cycle; fetch_count=4 after 4 fetches.
- Stall and memory wait:
  - Stimulus: at pc=5, stall=1 for 2 cycles, then imem_ready=0 for 3 cycles.
  - Response: pc stays 5 and if_valid=0 for all 5 cycles; next cycle pc=6.
- Simultaneous redirects:
  - Stimulus: at pc=8, ex_redirect=1 with ex_target=0x40, and id_redirect=1 with id_target=0x80, same cycle.
  - Response: flush_ifid=1, flush_idex=1, if_valid=0; next pc=0x40.
- Pending redirect:
  - Stimulus: pc=10, imem_ready=0; id_redirect with id_target=0x20 for one cycle; next cycle ex_redirect with ex_target=0x30; next cycle id_redirect with id_target=0x50; then imem_ready=1.
  - Response: on the first adv, pc=0x30 and if_valid=0 for that cycle; the following cycle pc=0x31 and if_valid=1.
- Halt:
  - Stimulus: pc=12, halt=1, adv=1.
  - Response: if_valid=1; pc=13; then imem_req=0 and pc frozen at 13 for 10 cycles despite imem_ready=1.
  - Stimulus: repeat with ex_redirect=1 in the same cycle.
  - Response: halt is ignored; pc=ex_target and state stays RUN.
- Reset mid-operation and wrap:
  - Stimulus: pend_valid=1 and reset low one cycle.
  - Response: pending entry discarded, pc=RESET_PC.
  - Stimulus: set pc=30'h3FFFFFFF via ex_target, then adv.
  - Response: pc=0.
